// File: rtl/riscv_pkg.sv
// Shared types for the RV32I integer register file: writeback source select,
// debug-port FSM states and the hard-wired zero register index.
package riscv_pkg;
  typedef enum logic [2:0] {
    WB_R    = 3'd0,
    WB_I    = 3'd1,
    WB_LOAD = 3'd2,
    WB_U    = 3'd3,
    WB_PC4  = 3'd4
  } wb_sel_e;

  typedef enum logic {
    DBG_IDLE = 1'b0,
    DBG_ACK  = 1'b1
  } dbg_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/Instr_IO.sv
// Instruction bus between fetch/decode, the register file and the execute units.
interface Instr_IO #(parameter int XLEN = 32);
  logic [31:0]     idata;
  logic [XLEN-1:0] rv1;
  logic [XLEN-1:0] rv2;

  modport reg_file_io_ports (input idata, output rv1, output rv2);
endinterface

// File: rtl/wb_mux.sv
// Writeback source select; unknown encodings produce no write (wvalid=0).
module wb_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  wb_sel_e         wb_sel,
  input  logic [XLEN-1:0] regdata_R,
  input  logic [XLEN-1:0] regdata_I,
  input  logic [XLEN-1:0] regdata_L,
  input  logic [XLEN-1:0] regdata_U,
  input  logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] wdata,
  output logic            wvalid
);
  always_comb begin
    wdata  = '0;
    wvalid = 1'b1;
    case (wb_sel)
      WB_R:    wdata = regdata_R;
      WB_I:    wdata = regdata_I;
      WB_LOAD: wdata = regdata_L;
      WB_U:    wdata = regdata_U;
      WB_PC4:  wdata = pc_plus4;
      default: wvalid = 1'b0;
    endcase
  end
endmodule

// File: rtl/reg_file.sv
// RV32I integer register file: x1..x31 in flops, combinational rv1/rv2 with
// optional write-first bypass, retired-write counter and a req/ack debug read.
module reg_file
  import riscv_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     idata,
  input  logic            reg_we,
  input  wb_sel_e         wb_sel,
  input  logic [XLEN-1:0] regdata_R,
  input  logic [XLEN-1:0] regdata_I,
  input  logic [XLEN-1:0] regdata_L,
  input  logic [XLEN-1:0] regdata_U,
  input  logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] rv1,
  output logic [XLEN-1:0] rv2,
  input  logic            dbg_req,
  input  logic [4:0]      dbg_addr,
  output logic            dbg_ack,
  output logic [XLEN-1:0] dbg_data,
  output logic [31:0]     wr_count
);
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] wdata;
  logic            wvalid, we;
  logic [XLEN-1:0] regs_q [1:31];
  logic [31:0]     wr_cnt_q;
  dbg_state_e      dbg_state_q, dbg_state_d;
  logic [XLEN-1:0] dbg_data_q, dbg_rd;
  logic            dbg_cap;
  logic            unused_idata;

  assign rs1 = idata[19:15];
  assign rs2 = idata[24:20];
  assign rd  = idata[11:7];
  assign unused_idata = ^{idata[31:25], idata[14:12], idata[6:0]};

  wb_mux #(.XLEN(XLEN)) u_wb_mux (
    .wb_sel    (wb_sel),
    .regdata_R (regdata_R),
    .regdata_I (regdata_I),
    .regdata_L (regdata_L),
    .regdata_U (regdata_U),
    .pc_plus4  (pc_plus4),
    .wdata     (wdata),
    .wvalid    (wvalid)
  );

  // rst_n gating keeps the bypass from leaking write data while in reset
  assign we = rst_n && reg_we && wvalid && (rd != REG_X0);

  function automatic logic [XLEN-1:0] rd_port(input logic [4:0] a, input logic byp);
    logic [XLEN-1:0] v;
    v = '0;
    if (a != REG_X0) begin
      v = regs_q[a];
      if (byp && we && (rd == a)) v = wdata;
    end
    return v;
  endfunction

  always_comb begin
    rv1    = rd_port(rs1, BYPASS);
    rv2    = rd_port(rs2, BYPASS);
    // debug capture always sees the same edge's commit, independent of BYPASS
    dbg_rd = rd_port(dbg_addr, 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
      wr_cnt_q <= '0;
    end else if (we) begin
      regs_q[rd] <= wdata;
      wr_cnt_q   <= wr_cnt_q + 32'd1;
    end
  end

  always_comb begin
    dbg_state_d = DBG_IDLE;
    dbg_cap     = 1'b0;
    case (dbg_state_q)
      DBG_IDLE: if (dbg_req) begin
        dbg_state_d = DBG_ACK;
        dbg_cap     = 1'b1;
      end
      DBG_ACK:  dbg_state_d = DBG_IDLE;
      default:  dbg_state_d = DBG_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbg_state_q <= DBG_IDLE;
      dbg_data_q  <= '0;
    end else begin
      dbg_state_q <= dbg_state_d;
      if (dbg_cap) dbg_data_q <= dbg_rd;
    end
  end

  assign dbg_ack  = (dbg_state_q == DBG_ACK);
  assign dbg_data = dbg_data_q;
  assign wr_count = wr_cnt_q;
endmodule
